// File: rtl/post_code_history_if.sv
// ISA bus signals that post_code_history_ctrl snoops.
//   isa_addr_en  : address enable, active low
//   isa_io_write : I/O write strobe, active low
//   isa_addr     : 20-bit address bus
//   isa_data     : 8-bit data bus
// master drives the bus (host or bench). slave only observes it (this block).
interface post_code_history_if;
  logic        isa_addr_en;
  logic        isa_io_write;
  logic [19:0] isa_addr;
  logic [7:0]  isa_data;

  modport master (
    output isa_addr_en,
    output isa_io_write,
    output isa_addr,
    output isa_data
  );

  modport slave (
    input isa_addr_en,
    input isa_io_write,
    input isa_addr,
    input isa_data
  );
endinterface

// File: rtl/post_code_history_ctrl.sv
// POST code capture with an eight-deep history and a timed display.
// Each code written to I/O port 0x80 is captured and shown live for
// LIVE_CYCLES cycles. When at least two codes are stored, the whole history
// is then replayed from oldest to newest, DWELL_CYCLES cycles per entry.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   bus                  : ISA snoop interface (slave modport)
//   clear                : synchronous history clear
//   post_code_present    : overlay enable (LIVE or REPLAY)
//   post_code_high_digit : ASCII hex digit for the upper nibble
//   post_code_low_digit  : ASCII hex digit for the lower nibble
//   post_code_replay     : high while replaying the history
//   history_count        : valid entries, 0..8
//   history_overflow     : sticky, set when a capture hits a full buffer
module post_code_history_ctrl #(
  parameter logic [27:0] LIVE_CYCLES  = 28'd143180000,
  parameter logic [27:0] DWELL_CYCLES = 28'd28636000
) (
  input  logic                      clk,
  input  logic                      reset,
  post_code_history_if.slave        bus,
  input  logic                      clear,
  output logic                      post_code_present,
  output logic [7:0]                post_code_high_digit,
  output logic [7:0]                post_code_low_digit,
  output logic                      post_code_replay,
  output logic [3:0]                history_count,
  output logic                      history_overflow
);

  typedef enum logic [1:0] {IDLE, LIVE, REPLAY} state_t;

  state_t      state_q;
  logic [27:0] timer_q;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rp_q;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        cs_q;
  logic        present_q, replay_q;
  logic [7:0]  hi_q, lo_q;
  logic [7:0]  mem_q [8];

  logic        cs, cap;
  logic [2:0]  oldest, newest, rp_next;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    return (n <= 4'd9) ? (8'h30 + n8) : (8'h37 + n8);
  endfunction

  assign cs  = (bus.isa_addr == 20'h80) & ~bus.isa_addr_en & ~bus.isa_io_write;
  // Only the first cycle of a cs assertion captures.
  assign cap = cs & ~cs_q;

  // With count == 8 the low bits are 0, so oldest == wr_ptr, as required.
  assign oldest  = wr_ptr_q - count_q[2:0];
  assign newest  = wr_ptr_q - 3'd1;
  assign rp_next = rp_q + 3'd1;

  // Pointer/count bookkeeping; clear beats a simultaneous capture.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = 3'd0;
      count_d  = 4'd0;
      ovf_d    = 1'b0;
    end else if (cap) begin
      wr_ptr_d = wr_ptr_q + 3'd1;
      if (count_q == 4'd8) ovf_d = 1'b1;
      else                 count_d = count_q + 4'd1;
    end
  end

  // History storage has no reset; entries beyond count are never shown.
  always_ff @(posedge clk) begin
    if (cap && !clear) mem_q[wr_ptr_q] <= bus.isa_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      wr_ptr_q  <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cs_q      <= 1'b0;
      present_q <= 1'b0;
      replay_q  <= 1'b0;
      hi_q      <= 8'h30;
      lo_q      <= 8'h30;
    end else begin
      cs_q     <= cs;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (clear) begin
        state_q   <= IDLE;
        timer_q   <= '0;
        present_q <= 1'b0;
        replay_q  <= 1'b0;
      end else if (cap) begin
        // A capture preempts whatever is on display, including a replay.
        state_q   <= LIVE;
        timer_q   <= '0;
        present_q <= 1'b1;
        replay_q  <= 1'b0;
        hi_q      <= hex_ascii(bus.isa_data[7:4]);
        lo_q      <= hex_ascii(bus.isa_data[3:0]);
      end else begin
        case (state_q)
          LIVE: begin
            if (timer_q == LIVE_CYCLES - 28'd1) begin
              timer_q <= '0;
              if (count_q >= 4'd2) begin
                state_q  <= REPLAY;
                replay_q <= 1'b1;
                rp_q     <= oldest;
                hi_q     <= hex_ascii(mem_q[oldest][7:4]);
                lo_q     <= hex_ascii(mem_q[oldest][3:0]);
              end else begin
                state_q   <= IDLE;
                present_q <= 1'b0;
              end
            end else begin
              timer_q <= timer_q + 28'd1;
            end
          end
          REPLAY: begin
            if (timer_q == DWELL_CYCLES - 28'd1) begin
              timer_q <= '0;
              if (rp_q == newest) begin
                state_q   <= IDLE;
                present_q <= 1'b0;
                replay_q  <= 1'b0;
              end else begin
                rp_q <= rp_next;
                hi_q <= hex_ascii(mem_q[rp_next][7:4]);
                lo_q <= hex_ascii(mem_q[rp_next][3:0]);
              end
            end else begin
              timer_q <= timer_q + 28'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign post_code_present    = present_q;
  assign post_code_replay     = replay_q;
  assign post_code_high_digit = hi_q;
  assign post_code_low_digit  = lo_q;
  assign history_count        = count_q;
  assign history_overflow     = ovf_q;

endmodule

// File: tb/tb_post_code_history_ctrl.sv
module tb_post_code_history_ctrl;
  localparam logic [27:0] LIVE  = 28'd20;
  localparam logic [27:0] DWELL = 28'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       present, replay, ovf;
  logic [7:0] hi, lo;
  logic [3:0] cnt;

  post_code_history_if bus();

  post_code_history_ctrl #(.LIVE_CYCLES(LIVE), .DWELL_CYCLES(DWELL)) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .clear                (clear),
    .post_code_present    (present),
    .post_code_high_digit (hi),
    .post_code_low_digit  (lo),
    .post_code_replay     (replay),
    .history_count        (cnt),
    .history_overflow     (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history as a queue (oldest first), display as a
  // countdown of cycles left on the current item.
  logic [7:0] hist[$];
  int         m_mode;   // 0 = dark, 1 = live, 2 = replay
  int         m_left;
  int         m_idx;
  logic       m_ovf;
  logic [7:0] m_code;
  logic       m_prev_cs;
  logic       m_cs, m_cap;
  string      hexs = "0123456789ABCDEF";

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_mode = 0; m_left = 0; m_idx = 0;
      m_ovf = 1'b0; m_code = 8'h00; m_prev_cs = 1'b0;
    end else begin
      m_cs  = (bus.isa_addr == 20'h80) && !bus.isa_addr_en && !bus.isa_io_write;
      m_cap = m_cs && !m_prev_cs;
      m_prev_cs = m_cs;
      if (clear) begin
        hist.delete();
        m_ovf = 1'b0;
        m_mode = 0;
      end else if (m_cap) begin
        if (hist.size() == 8) begin
          void'(hist.pop_front());
          m_ovf = 1'b1;
        end
        hist.push_back(bus.isa_data);
        m_mode = 1; m_left = int'(LIVE); m_code = bus.isa_data;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          if (hist.size() >= 2) begin
            m_mode = 2; m_idx = 0; m_code = hist[0]; m_left = int'(DWELL);
          end else m_mode = 0;
        end
      end else if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin
          m_idx++;
          if (m_idx == hist.size()) m_mode = 0;
          else begin
            m_code = hist[m_idx]; m_left = int'(DWELL);
          end
        end
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_present", {31'b0, present}, {31'b0, m_mode != 0});
      check("model_replay",  {31'b0, replay},  {31'b0, m_mode == 2});
      check("model_hi",      {24'b0, hi},      {24'b0, hexs[m_code[7:4]]});
      check("model_lo",      {24'b0, lo},      {24'b0, hexs[m_code[3:0]]});
      check("model_count",   {28'b0, cnt},     32'(hist.size()));
      check("model_ovf",     {31'b0, ovf},     {31'b0, m_ovf});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_release();
    bus.isa_addr_en = 1'b1; bus.isa_io_write = 1'b1; bus.isa_addr = 20'h0;
  endtask

  // Holds the bus cycle for 'hold' edges; a capture lands on the first one.
  task automatic bus_write(input logic [19:0] a, input logic wr_n, input logic [7:0] d, input int hold);
    bus.isa_addr_en = 1'b0; bus.isa_io_write = wr_n; bus.isa_addr = a; bus.isa_data = d;
    tick(hold);
    bus_release();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
  endtask

  typedef struct packed {
    logic [19:0] addr;
    logic        wr_n;
    logic [7:0]  data;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [3:0]  cnt;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = {20'h80, 1'b0, 8'h3C, 8'h33, 8'h43, 4'd1};
    tbl[1] = {20'h81, 1'b0, 8'h85, 8'h33, 8'h43, 4'd1};
    tbl[2] = {20'h80, 1'b1, 8'h85, 8'h33, 8'h43, 4'd1};
    tbl[3] = {20'h80, 1'b0, 8'hAF, 8'h41, 8'h46, 4'd2};
    tbl[4] = {20'h80, 1'b0, 8'h09, 8'h30, 8'h39, 4'd3};
    tbl[5] = {20'h80, 1'b0, 8'hF0, 8'h46, 8'h30, 4'd4};

    reset = 1'b1; clear = 1'b0; bus.isa_data = 8'h00; bus_release();
    tick(3);
    check("rst_present", {31'b0, present}, 32'd0);
    check("rst_replay",  {31'b0, replay},  32'd0);
    check("rst_hi",      {24'b0, hi},      32'h30);
    check("rst_lo",      {24'b0, lo},      32'h30);
    check("rst_count",   {28'b0, cnt},     32'd0);
    check("rst_ovf",     {31'b0, ovf},     32'd0);
    reset = 1'b0;
    tick(1);
    chk_en = 1;

    // Table: capture/non-capture cycles, digits one clock after the first cs cycle.
    for (int i = 0; i < 6; i++) begin
      bus.isa_addr_en = 1'b0; bus.isa_io_write = tbl[i].wr_n;
      bus.isa_addr = tbl[i].addr; bus.isa_data = tbl[i].data;
      tick(1);
      check("tbl_present", {31'b0, present}, 32'd1);
      check("tbl_hi",      {24'b0, hi},      {24'b0, tbl[i].hi});
      check("tbl_lo",      {24'b0, lo},      {24'b0, tbl[i].lo});
      check("tbl_count",   {28'b0, cnt},     {28'b0, tbl[i].cnt});
      tick(1);
      bus_release();
      tick(1);
    end
    do_clear();
    tick(2);

    // Single write held 4 cycles; live for exactly 20 cycles.
    bus_write(20'h80, 1'b0, 8'h3C, 1);
    check("single_hi",      {24'b0, hi},      32'h33);
    check("single_lo",      {24'b0, lo},      32'h43);
    check("single_present", {31'b0, present}, 32'd1);
    bus.isa_addr_en = 1'b0; bus.isa_io_write = 1'b0; bus.isa_addr = 20'h80;
    tick(3);
    bus_release();
    tick(16);
    check("single_still_on", {31'b0, present}, 32'd1);
    tick(1);
    check("single_off",   {31'b0, present}, 32'd0);
    check("single_count", {28'b0, cnt},     32'd1);

    // Replay order 01, 02, 03.
    do_clear();
    bus_write(20'h80, 1'b0, 8'h01, 2); tick(1);
    bus_write(20'h80, 1'b0, 8'h02, 2); tick(1);
    bus_write(20'h80, 1'b0, 8'h03, 2);
    tick(19);
    check("rep_replay", {31'b0, replay}, 32'd1);
    check("rep_e0_lo",  {24'b0, lo},     32'h31);
    tick(9);
    check("rep_e0_end", {24'b0, lo},     32'h31);
    tick(1);
    check("rep_e1_lo",  {24'b0, lo},     32'h32);
    tick(10);
    check("rep_e2_lo",  {24'b0, lo},     32'h33);
    tick(10);
    check("rep_done_present", {31'b0, present}, 32'd0);
    check("rep_done_replay",  {31'b0, replay},  32'd0);

    // Overflow: ten writes 0x10..0x19.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      bus_write(20'h80, 1'b0, 8'h10 + 8'(i), 1);
      tick(1);
    end
    check("ovf_count", {28'b0, cnt}, 32'd8);
    check("ovf_flag",  {31'b0, ovf}, 32'd1);
    tick(19);
    for (int k = 0; k < 8; k++) begin
      check("ovf_rep_hi", {24'b0, hi}, 32'h31);
      check("ovf_rep_lo", {24'b0, lo}, 32'h32 + 32'(k));
      tick(10);
    end
    check("ovf_rep_done", {31'b0, present}, 32'd0);
    bus_write(20'h80, 1'b0, 8'h77, 2);
    do_clear();
    check("clr_count",   {28'b0, cnt},     32'd0);
    check("clr_ovf",     {31'b0, ovf},     32'd0);
    check("clr_present", {31'b0, present}, 32'd0);

    // Abort during replay and bus cycles that must be ignored.
    bus_write(20'h80, 1'b0, 8'hAA, 2); tick(1);
    bus_write(20'h80, 1'b0, 8'hCC, 2);
    tick(19);
    check("abort_replay_on", {31'b0, replay}, 32'd1);
    tick(4);
    bus_write(20'h80, 1'b0, 8'hBB, 1);
    check("abort_replay_off", {31'b0, replay},  32'd0);
    check("abort_present",    {31'b0, present}, 32'd1);
    check("abort_hi",         {24'b0, hi},      32'h42);
    check("abort_lo",         {24'b0, lo},      32'h42);
    tick(20);
    check("abort_rerun",    {31'b0, replay}, 32'd1);
    check("abort_rerun_hi", {24'b0, hi},     32'h41);
    check("abort_rerun_lo", {24'b0, lo},     32'h41);
    bus_write(20'h81, 1'b0, 8'h85, 2);
    bus_write(20'h80, 1'b1, 8'h85, 2);
    check("ignore_count",  {28'b0, cnt},    32'd3);
    check("ignore_replay", {31'b0, replay}, 32'd1);
    check("ignore_hi",     {24'b0, hi},     32'h41);

    // Clear coincident with a capture, then mid-LIVE asynchronous reset.
    tick(40);
    bus.isa_addr_en = 1'b0; bus.isa_io_write = 1'b0; bus.isa_addr = 20'h80; bus.isa_data = 8'h55;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("coll_count",   {28'b0, cnt},     32'd0);
    check("coll_present", {31'b0, present}, 32'd0);
    tick(1);
    check("coll_no_recap", {28'b0, cnt}, 32'd0);
    bus_release();
    tick(1);
    bus_write(20'h80, 1'b0, 8'h66, 2);
    tick(5);
    check("live_before_rst", {31'b0, present}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_present", {31'b0, present}, 32'd0);
    check("arst_hi",      {24'b0, hi},      32'h30);
    check("arst_lo",      {24'b0, lo},      32'h30);
    check("arst_count",   {28'b0, cnt},     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(3);
    check("post_rst_idle", {31'b0, present}, 32'd0);

    // Random bus traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        do_clear();
      end else if (r < 70) begin
        bus_write(($urandom_range(0, 9) == 0) ? 20'(32'h80 + $urandom_range(1, 3)) : 20'h80,
                  ($urandom_range(0, 9) == 0), 8'($urandom), $urandom_range(1, 4));
      end
      tick($urandom_range(0, 30));
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
